// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT consecutive unsigned products from the
// upstream multiplier and presents each completed sum, along with a sticky
// carry-out flag, through a valid/ready result port.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds valid and its data stable
// until that transfer. Here prod_ready_o depends only on state (high in ACCUM).
// res_valid_o is high only in OUT, and result_o/overflow_o are registered, so
// they stay stable while the result waits for res_ready_i.
module product_accumulator #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned COUNT  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              prod_valid_i,
  output logic              prod_ready_o,
  input  logic [PROD_W-1:0] product_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [ACC_W-1:0]  result_o,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   res_q, res_d;
  logic               res_ovf_q, res_ovf_d;

  // One extra bit on the sum captures the carry out of the accumulator.
  logic [ACC_W:0]     sum;
  logic               last;

  // Running sum with zero-extended product, and detection of the batch's final product.
  always_comb begin
    sum  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, product_i};
    last = (cnt_q == CNT_W'(COUNT - 1));
  end

  // Next-state and datapath updates; clear_i takes priority over both handshakes.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    res_ovf_d = res_ovf_q;
    case (state_q)
      ACCUM: begin
        if (clear_i) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (prod_valid_i) begin
          if (last) begin
            res_d     = sum[ACC_W-1:0];
            res_ovf_d = ovf_q | sum[ACC_W];
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = ovf_q | sum[ACC_W];
            state_d   = OUT;
          end else begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      OUT: begin
        // Either a flush or a result handshake ends the batch; no product is taken here.
        if (clear_i || res_ready_i) begin
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  // Port outputs decoded from registered state only.
  always_comb begin
    prod_ready_o = (state_q == ACCUM);
    res_valid_o  = (state_q == OUT);
    result_o     = res_q;
    overflow_o   = res_ovf_q;
    busy_o       = (state_q == OUT) || (cnt_q != '0);
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: three instances cover
// COUNT=4/ACC_W=16, COUNT=4/ACC_W=9 (wrap and overflow) and COUNT=1.
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst_n;

  // Clock generation.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: COUNT=4, ACC_W=16.
  logic        a_clear, a_pv, a_rr;
  logic [7:0]  a_prod;
  logic        a_pr, a_rv, a_ovf, a_busy;
  logic [15:0] a_res;

  // Instance B: COUNT=4, ACC_W=9.
  logic        b_clear, b_pv, b_rr;
  logic [7:0]  b_prod;
  logic        b_pr, b_rv, b_ovf, b_busy;
  logic [8:0]  b_res;

  // Instance C: COUNT=1, ACC_W=16.
  logic        c_clear, c_pv, c_rr;
  logic [7:0]  c_prod;
  logic        c_pr, c_rv, c_ovf, c_busy;
  logic [15:0] c_res;

  product_accumulator #(.PROD_W(8), .ACC_W(16), .COUNT(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear),
    .prod_valid_i(a_pv), .prod_ready_o(a_pr), .product_i(a_prod),
    .res_valid_o(a_rv), .res_ready_i(a_rr), .result_o(a_res),
    .overflow_o(a_ovf), .busy_o(a_busy)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(9), .COUNT(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear),
    .prod_valid_i(b_pv), .prod_ready_o(b_pr), .product_i(b_prod),
    .res_valid_o(b_rv), .res_ready_i(b_rr), .result_o(b_res),
    .overflow_o(b_ovf), .busy_o(b_busy)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(16), .COUNT(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(c_clear),
    .prod_valid_i(c_pv), .prod_ready_o(c_pr), .product_i(c_prod),
    .res_valid_o(c_rv), .res_ready_i(c_rr), .result_o(c_res),
    .overflow_o(c_ovf), .busy_o(c_busy)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one product for a single cycle on instance A (accepted when ready).
  task automatic send_a(input logic [7:0] p);
    a_pv   = 1'b1;
    a_prod = p;
    tick();
    a_pv   = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] p);
    b_pv   = 1'b1;
    b_prod = p;
    tick();
    b_pv   = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    a_clear = 1'b0; a_pv = 1'b0; a_rr = 1'b0; a_prod = '0;
    b_clear = 1'b0; b_pv = 1'b0; b_rr = 1'b0; b_prod = '0;
    c_clear = 1'b0; c_pv = 1'b0; c_rr = 1'b0; c_prod = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state.
    chk("rst_a_ready", a_pr, 1);
    chk("rst_a_valid", a_rv, 0);
    chk("rst_a_result", a_res, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_b_ready", b_pr, 1);
    chk("rst_c_valid", c_rv, 0);

    // 225 x4 back-to-back with downstream always ready: 900 = 0x0384.
    a_rr = 1'b1;
    send_a(8'd225);
    chk("b2b_busy_mid", a_busy, 1);
    chk("b2b_valid_mid", a_rv, 0);
    send_a(8'd225);
    send_a(8'd225);
    send_a(8'd225);
    chk("b2b_valid", a_rv, 1);
    chk("b2b_result", a_res, 32'h0384);
    chk("b2b_ovf", a_ovf, 0);
    chk("b2b_ready_out", a_pr, 0);
    tick();
    chk("b2b_valid_1cyc", a_rv, 0);
    chk("b2b_ready_back", a_pr, 1);
    chk("b2b_busy_idle", a_busy, 0);
    chk("b2b_result_hold", a_res, 900);

    // 1,2,3,4 with gaps 0/3/1, then backpressure for 5 cycles with a product offered.
    a_rr = 1'b0;
    send_a(8'd1);
    send_a(8'd2);
    tick(); tick(); tick();
    chk("gap_partial_busy", a_busy, 1);
    chk("gap_no_valid", a_rv, 0);
    send_a(8'd3);
    tick();
    send_a(8'd4);
    a_pv   = 1'b1;
    a_prod = 8'd99;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", a_rv, 1);
      chk("bp_result", a_res, 10);
      chk("bp_ready_low", a_pr, 0);
      tick();
    end
    a_pv = 1'b0;
    a_rr = 1'b1;
    tick();
    chk("bp_released", a_rv, 0);
    chk("bp_no_stray_accept", a_busy, 0);

    // Clear mid-batch with a third product presented: nothing accumulates.
    send_a(8'd50);
    send_a(8'd60);
    chk("clr_busy_before", a_busy, 1);
    a_clear = 1'b1;
    a_pv    = 1'b1;
    a_prod  = 8'd70;
    tick();
    a_clear = 1'b0;
    a_pv    = 1'b0;
    chk("clr_busy_after", a_busy, 0);
    chk("clr_no_result", a_rv, 0);
    send_a(8'd1);
    send_a(8'd2);
    send_a(8'd3);
    chk("clr_no_early_result", a_rv, 0);
    send_a(8'd4);
    chk("clr_valid", a_rv, 1);
    chk("clr_result", a_res, 10);
    tick();

    // Clear while a result is pending discards it; result_o keeps the last value.
    a_rr = 1'b0;
    send_a(8'd1);
    send_a(8'd1);
    send_a(8'd1);
    send_a(8'd1);
    chk("clrout_valid", a_rv, 1);
    chk("clrout_result", a_res, 4);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    chk("clrout_dropped", a_rv, 0);
    chk("clrout_ready", a_pr, 1);
    chk("clrout_hold", a_res, 4);

    // Reset with result 900 pending.
    send_a(8'd225);
    send_a(8'd225);
    send_a(8'd225);
    send_a(8'd225);
    tick();
    chk("rstout_pending", a_rv, 1);
    chk("rstout_result", a_res, 900);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstout_valid", a_rv, 0);
    chk("rstout_result0", a_res, 0);
    chk("rstout_busy", a_busy, 0);
    chk("rstout_ready", a_pr, 1);
    a_rr = 1'b1;
    send_a(8'd5);
    send_a(8'd5);
    send_a(8'd5);
    send_a(8'd5);
    chk("rstout_fresh_valid", a_rv, 1);
    chk("rstout_fresh_result", a_res, 20);
    tick();

    // ACC_W=9: 4 x 255 = 1020 -> 508 with overflow; next batch clears overflow.
    b_rr = 1'b1;
    send_b(8'd255);
    send_b(8'd255);
    send_b(8'd255);
    send_b(8'd255);
    chk("w9_valid", b_rv, 1);
    chk("w9_result", b_res, 508);
    chk("w9_ovf", b_ovf, 1);
    tick();
    chk("w9_busy_idle", b_busy, 0);
    send_b(8'd1);
    send_b(8'd1);
    send_b(8'd1);
    send_b(8'd1);
    chk("w9_next_result", b_res, 4);
    chk("w9_next_ovf", b_ovf, 0);
    tick();

    // COUNT=1: products 7 then 9 held valid; results two cycles apart.
    c_rr   = 1'b1;
    c_pv   = 1'b1;
    c_prod = 8'd7;
    tick();
    c_prod = 8'd9;
    chk("c1_valid7", c_rv, 1);
    chk("c1_result7", c_res, 7);
    chk("c1_ready_out", c_pr, 0);
    chk("c1_busy_out", c_busy, 1);
    tick();
    chk("c1_gap_valid", c_rv, 0);
    chk("c1_gap_ready", c_pr, 1);
    tick();
    c_pv = 1'b0;
    chk("c1_valid9", c_rv, 1);
    chk("c1_result9", c_res, 9);
    chk("c1_ready_out9", c_pr, 0);
    tick();
    chk("c1_done", c_rv, 0);
    chk("c1_ovf", c_ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
